// File: rtl/rr_mux_reg_pkg.sv
// ---------------------------------------------------------------------------
// mux_defs
//   Definitions shared by rr_mux_reg and rr_arbiter:
//     MODE_SEL / MODE_RR : source-selection modes for rr_mux_reg
//     sel_width(n)       : width of a channel index for n channels (min 1)
// ---------------------------------------------------------------------------
package mux_defs;

  localparam int MODE_SEL = 0;  // channel chosen by the explicit sel input
  localparam int MODE_RR  = 1;  // channel chosen by round-robin arbitration

  // A single channel still needs a 1-bit index so ports never collapse to
  // zero width.
  function automatic int sel_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage : mux_defs

// File: rtl/rr_mux_reg_arbiter.sv
// ---------------------------------------------------------------------------
// rr_arbiter
//   Combinational round-robin arbiter. Grants the first requester found when
//   scanning i_ptr, i_ptr+1, .. N-1, 0, .. i_ptr-1.
//   Ports:
//     i_req   [N]    request per channel
//     i_ptr   [SELW] highest-priority channel this cycle
//     o_grant [N]    one-hot grant (all zero when nothing is requested)
//     o_idx   [SELW] encoded index of the granted channel (0 when none)
// ---------------------------------------------------------------------------
module rr_arbiter
  import mux_defs::*;
#(
  parameter  int N    = 4,
  localparam int SELW = sel_width(N)
) (
  input  logic [N-1:0]    i_req,
  input  logic [SELW-1:0] i_ptr,
  output logic [N-1:0]    o_grant,
  output logic [SELW-1:0] o_idx
);

  logic w_found;

  // Two passes give the wrap-around order without modulo arithmetic:
  // first the channels at or above the pointer, then those below it.
  always_comb begin
    // NOTE: every combinational output gets a default before any branch, so
    // no path leaves it unassigned and no latch is inferred.
    o_grant = '0;
    o_idx   = '0;
    w_found = 1'b0;
    for (int i = 0; i < N; i++) begin
      if (!w_found && i_req[i] && (i >= int'(i_ptr))) begin
        w_found    = 1'b1;
        o_grant[i] = 1'b1;
        o_idx      = SELW'(i);
      end
    end
    for (int i = 0; i < N; i++) begin
      if (!w_found && i_req[i] && (i < int'(i_ptr))) begin
        w_found    = 1'b1;
        o_grant[i] = 1'b1;
        o_idx      = SELW'(i);
      end
    end
  end

endmodule : rr_arbiter

// File: rtl/rr_mux_reg.sv
// ---------------------------------------------------------------------------
// rr_mux_reg
//   N-channel, WIDTH-bit registered multiplexer with valid/ready handshakes.
//   One source per cycle is chosen by sel (MODE_SEL) or by round-robin
//   arbitration (MODE_RR); the chosen word is held in an output register
//   until the consumer takes it.
//   Ports:
//     clk, rst_n           clock, asynchronous active-low reset
//     in_data  [N*WIDTH]   channel i word at [i*WIDTH +: WIDTH]
//     in_valid [N]         channel i offers a word
//     in_ready [N]         channel i word accepted this cycle
//     sel      [SELW]      channel to pass (MODE_SEL only)
//     out_data [WIDTH]     registered selected word
//     out_src  [SELW]      channel that supplied out_data
//     out_valid            out_data/out_src hold an unconsumed word
//     out_ready            consumer takes out_data this cycle
// ---------------------------------------------------------------------------
module rr_mux_reg
  import mux_defs::*;
#(
  parameter  int WIDTH = 32,
  parameter  int N     = 4,
  parameter  int MODE  = MODE_SEL,
  localparam int SELW  = sel_width(N)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [N*WIDTH-1:0]   in_data,
  input  logic [N-1:0]         in_valid,
  output logic [N-1:0]         in_ready,
  input  logic [SELW-1:0]      sel,
  output logic [WIDTH-1:0]     out_data,
  output logic [SELW-1:0]      out_src,
  output logic                 out_valid,
  input  logic                 out_ready
);

  logic [N-1:0]     w_grant;
  logic [SELW-1:0]  w_idx;
  logic             w_load_en;
  logic             w_xfer;
  logic [WIDTH-1:0] w_sel_data;

  logic [WIDTH-1:0] r_out_data;
  logic [SELW-1:0]  r_out_src;
  logic             r_out_valid;

  // The slot can take a new word when it is empty or being drained this
  // cycle, which gives one word per cycle with no bubble.
  assign w_load_en = !r_out_valid || out_ready;

  // ---------------------------------------------------------------------
  // Grant selection
  // ---------------------------------------------------------------------
  if (MODE == MODE_RR) begin : g_rr
    logic [SELW-1:0] r_rr_ptr;
    logic            w_unused_sel;

    assign w_unused_sel = ^sel;

    rr_arbiter #(.N(N)) u_arb (
      .i_req   (in_valid),
      .i_ptr   (r_rr_ptr),
      .o_grant (w_grant),
      .o_idx   (w_idx)
    );

    // The pointer moves past the winner only when a word actually moves,
    // so idle or stalled cycles never skip a channel's turn.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        r_rr_ptr <= '0;
      end else if (w_xfer) begin
        r_rr_ptr <= (w_idx == SELW'(N - 1)) ? '0 : w_idx + 1'b1;
      end
    end
  end else if (N == 1) begin : g_one
    logic w_unused_sel;

    assign w_unused_sel = ^sel;
    assign w_grant      = in_valid;
    assign w_idx        = '0;
  end else begin : g_sel
    // An out-of-range sel (non-power-of-2 N) matches no channel, so nothing
    // is granted.
    always_comb begin
      w_grant = '0;
      w_idx   = '0;
      for (int i = 0; i < N; i++) begin
        if ((int'(sel) == i) && in_valid[i]) begin
          w_grant[i] = 1'b1;
          w_idx      = SELW'(i);
        end
      end
    end
  end

  assign in_ready = w_load_en ? w_grant : '0;
  assign w_xfer   = |in_ready;

  // Grant is one-hot, so at most one term drives the data.
  always_comb begin
    w_sel_data = '0;
    for (int i = 0; i < N; i++) begin
      if (w_grant[i]) begin
        w_sel_data = in_data[i*WIDTH +: WIDTH];
      end
    end
  end

  // ---------------------------------------------------------------------
  // Output register
  // ---------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_out_src   <= '0;
    end else if (w_xfer) begin
      // NOTE: non-blocking assignments make every register here update from
      // the same pre-edge values, independent of statement order.
      r_out_valid <= 1'b1;
      r_out_data  <= w_sel_data;
      r_out_src   <= w_idx;
    end else if (out_ready) begin
      // Drained with nothing to replace it: data and source keep their
      // last value.
      r_out_valid <= 1'b0;
    end
  end

  assign out_data  = r_out_data;
  assign out_src   = r_out_src;
  assign out_valid = r_out_valid;

endmodule : rr_mux_reg

// File: tb/tb_rr_mux_reg.sv
// ---------------------------------------------------------------------------
// tb_rr_mux_reg
//   Directed bench for rr_mux_reg with three instances:
//     u_sel4 : WIDTH=32, N=4, MODE_SEL
//     u_rr4  : WIDTH=32, N=4, MODE_RR
//     u_sel3 : WIDTH=8,  N=3, MODE_SEL
//   Inputs change 1 time unit after a rising edge; outputs are sampled there.
// ---------------------------------------------------------------------------
module tb_rr_mux_reg;
  import mux_defs::*;

  logic clk;
  logic rst_n;

  int total = 0;
  int bad   = 0;

  // MODE_SEL, N=4, WIDTH=32
  logic [127:0] a_in_data;
  logic [3:0]   a_in_valid, a_in_ready;
  logic [1:0]   a_sel, a_out_src;
  logic [31:0]  a_out_data;
  logic         a_out_valid, a_out_ready;

  // MODE_RR, N=4, WIDTH=32
  logic [127:0] b_in_data;
  logic [3:0]   b_in_valid, b_in_ready;
  logic [1:0]   b_sel, b_out_src;
  logic [31:0]  b_out_data;
  logic         b_out_valid, b_out_ready;

  // MODE_SEL, N=3, WIDTH=8
  logic [23:0]  c_in_data;
  logic [2:0]   c_in_valid, c_in_ready;
  logic [1:0]   c_sel, c_out_src;
  logic [7:0]   c_out_data;
  logic         c_out_valid, c_out_ready;

  rr_mux_reg #(.WIDTH(32), .N(4), .MODE(MODE_SEL)) u_sel4 (
    .clk(clk), .rst_n(rst_n), .in_data(a_in_data), .in_valid(a_in_valid),
    .in_ready(a_in_ready), .sel(a_sel), .out_data(a_out_data),
    .out_src(a_out_src), .out_valid(a_out_valid), .out_ready(a_out_ready)
  );

  rr_mux_reg #(.WIDTH(32), .N(4), .MODE(MODE_RR)) u_rr4 (
    .clk(clk), .rst_n(rst_n), .in_data(b_in_data), .in_valid(b_in_valid),
    .in_ready(b_in_ready), .sel(b_sel), .out_data(b_out_data),
    .out_src(b_out_src), .out_valid(b_out_valid), .out_ready(b_out_ready)
  );

  rr_mux_reg #(.WIDTH(8), .N(3), .MODE(MODE_SEL)) u_sel3 (
    .clk(clk), .rst_n(rst_n), .in_data(c_in_data), .in_valid(c_in_valid),
    .in_ready(c_in_ready), .sel(c_sel), .out_data(c_out_data),
    .out_src(c_out_src), .out_valid(c_out_valid), .out_ready(c_out_ready)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [3:0] exp_rdy;
    int         order [6];

    order = '{0, 1, 2, 3, 0, 1};

    rst_n       = 1'b0;
    a_in_data   = '0; a_in_valid = '0; a_sel = '0; a_out_ready = 1'b0;
    b_in_data   = '0; b_in_valid = '0; b_sel = '0; b_out_ready = 1'b0;
    c_in_data   = '0; c_in_valid = '0; c_sel = '0; c_out_ready = 1'b0;

    // Reset state
    #1;
    check("rst_a_valid", a_out_valid, 0);
    check("rst_a_data",  a_out_data,  0);
    check("rst_a_src",   a_out_src,   0);
    check("rst_b_valid", b_out_valid, 0);
    check("rst_c_valid", c_out_valid, 0);
    tick();
    tick();
    rst_n = 1'b1;
    tick();

    // 1. Asynchronous reset while a word is held
    a_sel            = 2'd0;
    a_in_data[31:0]  = 32'hDEADBEEF;
    a_in_valid       = 4'b0001;
    a_out_ready      = 1'b0;
    #1;
    check("t1_load_rdy", a_in_ready, 4'b0001);
    tick();
    a_in_valid = 4'b0000;
    check("t1_held_valid", a_out_valid, 1);
    check("t1_held_data",  a_out_data,  32'hDEADBEEF);
    #2 rst_n = 1'b0;
    #1;
    check("t1_async_valid", a_out_valid, 0);
    check("t1_async_data",  a_out_data,  0);
    check("t1_async_src",   a_out_src,   0);
    #1 rst_n = 1'b1;
    tick();

    // 2. MODE_SEL, sel=2, all valid
    a_in_data   = {32'h33, 32'h22, 32'h11, 32'h00};
    a_in_valid  = 4'b1111;
    a_sel       = 2'd2;
    a_out_ready = 1'b1;
    #1;
    check("t2_in_ready", a_in_ready, 4'b0100);
    tick();
    check("t2_out_valid", a_out_valid, 1);
    check("t2_out_data",  a_out_data,  32'h22);
    check("t2_out_src",   a_out_src,   2);
    // Selected channel not valid: no grant; slot drains, data holds.
    a_sel      = 2'd3;
    a_in_valid = 4'b0111;
    #1;
    check("t2_novalid_rdy", a_in_ready, 4'b0000);
    tick();
    check("t2_drain_valid", a_out_valid, 0);
    check("t2_drain_data",  a_out_data,  32'h22);
    check("t2_drain_src",   a_out_src,   2);

    // 5. Backpressure, then drain and load in the same cycle
    a_sel           = 2'd0;
    a_in_valid      = 4'b0001;
    a_in_data[31:0] = 32'h55;
    tick();
    check("t5_load_data", a_out_data, 32'h55);
    a_out_ready     = 1'b0;
    a_in_data[31:0] = 32'h77;
    a_in_data[95:64] = 32'h99;
    a_in_valid      = 4'b0101;
    for (int k = 0; k < 3; k++) begin
      if (k == 1) a_sel = 2'd2;  // sel change while held must not matter
      #1;
      check("t5_bp_rdy", a_in_ready, 4'b0000);
      tick();
      check("t5_bp_valid", a_out_valid, 1);
      check("t5_bp_data",  a_out_data,  32'h55);
      check("t5_bp_src",   a_out_src,   0);
    end
    a_sel           = 2'd0;
    a_in_data[31:0] = 32'h66;
    a_out_ready     = 1'b1;
    #1;
    check("t5_reload_rdy", a_in_ready, 4'b0001);
    tick();
    check("t5_reload_valid", a_out_valid, 1);
    check("t5_reload_data",  a_out_data,  32'h66);
    a_in_valid = 4'b0000;
    tick();
    check("t5_idle_valid", a_out_valid, 0);

    // 3. MODE_RR, all valid for 6 cycles
    b_in_data   = {32'hB3, 32'hB2, 32'hB1, 32'hB0};
    b_in_valid  = 4'b1111;
    b_out_ready = 1'b1;
    for (int k = 0; k < 6; k++) begin
      exp_rdy = 4'b0001 << order[k];
      #1;
      check("t3_rr_rdy", b_in_ready, exp_rdy);
      tick();
      check("t3_rr_src",  b_out_src,  order[k]);
      check("t3_rr_data", b_out_data, 32'hB0 + order[k]);
    end
    // Pointer now 2. Idle cycles must not move it.
    b_in_valid = 4'b0000;
    tick();
    check("t3_idle_valid", b_out_valid, 0);
    tick();

    // 4. MODE_RR with gaps, pointer 2
    b_in_valid = 4'b1010;
    #1;
    check("t4_g3_rdy", b_in_ready, 4'b1000);
    tick();
    check("t4_g3_src", b_out_src, 3);
    #1;
    check("t4_g1_rdy", b_in_ready, 4'b0010);
    tick();
    check("t4_g1_src",  b_out_src,  1);
    check("t4_g1_data", b_out_data, 32'hB1);
    #1;
    check("t4_g3b_rdy", b_in_ready, 4'b1000);
    tick();
    check("t4_g3b_src", b_out_src, 3);
    // Pointer now 0. Stall with all valid: no ready, pointer holds.
    b_out_ready = 1'b0;
    b_in_valid  = 4'b1111;
    tick();
    check("t4_stall_rdy",  b_in_ready, 4'b0000);
    check("t4_stall_src",  b_out_src,  3);
    check("t4_stall_data", b_out_data, 32'hB3);
    b_out_ready = 1'b1;
    #1;
    check("t4_resume_rdy", b_in_ready, 4'b0001);
    tick();
    check("t4_resume_src", b_out_src, 0);
    b_in_valid = 4'b0000;

    // 6. WIDTH=8, N=3, MODE_SEL: out-of-range select, then sel=1
    c_in_data   = {8'hC2, 8'hC1, 8'hC0};
    c_in_valid  = 3'b111;
    c_sel       = 2'd3;
    c_out_ready = 1'b1;
    #1;
    check("t6_oor_rdy", c_in_ready, 3'b000);
    tick();
    check("t6_oor_valid", c_out_valid, 0);
    c_sel = 2'd1;
    #1;
    check("t6_sel1_rdy", c_in_ready, 3'b010);
    tick();
    check("t6_sel1_valid", c_out_valid, 1);
    check("t6_sel1_data",  c_out_data,  8'hC1);
    check("t6_sel1_src",   c_out_src,   1);
    c_sel = 2'd2;
    #1;
    check("t6_sel2_rdy", c_in_ready, 3'b100);
    tick();
    check("t6_sel2_data", c_out_data, 8'hC2);
    check("t6_sel2_src",  c_out_src,  2);
    c_in_valid = 3'b000;
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_rr_mux_reg
